// File: rtl/skid_pkg.sv
// Shared types for the skid_reg elastic pipeline register.
// The state encoding puts in_ready in bit 0 and out_valid in bit 1, so both outputs come straight from flops.
package skid_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b01;
  localparam logic [1:0] ST_ONE   = 2'b11;
  localparam logic [1:0] ST_TWO   = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    TWO   = ST_TWO
  } skid_state_t;

endpackage

// File: rtl/skid_reg_flopre.sv
// Resettable flop with enable (synchronous, active-high reset).
module flopre #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid buffer with valid/ready on both sides; all outputs registered.
// Optional flush port enabled by defining SKID_FLUSH_EN.
module skid_reg
  import skid_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
`ifdef SKID_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         in_valid,
  input  logic [N-1:0] in_d,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_q,
  input  logic         out_ready
);

  skid_state_t  state, state_next;
  logic         main_en, skid_en;
  logic [N-1:0] main_d, skid_d, main_q, skid_q;
  logic         accept_c, consume_c, flush_c;

`ifdef SKID_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  assign in_ready  = state[0];
  assign out_valid = state[1];
  assign out_q     = main_q;

  assign accept_c  = in_valid && in_ready;
  assign consume_c = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next state and entry load enables; flush overrides everything but reset.
  always_comb begin
    state_next = state;
    main_en    = 1'b0;
    main_d     = in_d;
    skid_en    = 1'b0;
    skid_d     = in_d;
    case (state)
      EMPTY: begin
        if (accept_c) begin
          state_next = ONE;
          main_en    = 1'b1;
        end
      end
      ONE: begin
        if (accept_c && consume_c) begin
          main_en = 1'b1;
        end else if (accept_c) begin
          state_next = TWO;
          skid_en    = 1'b1;
        end else if (consume_c) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (consume_c) begin
          state_next = ONE;
          main_en    = 1'b1;
          main_d     = skid_q;
          skid_en    = 1'b1;
          skid_d     = '0;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush_c) begin
      state_next = EMPTY;
      main_en    = 1'b1;
      main_d     = '0;
      skid_en    = 1'b1;
      skid_d     = '0;
    end
  end

  flopre #(.N(N)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  flopre #(.N(N)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_skid_reg.sv
// Directed bench for skid_reg: reset, streaming, stall, alternating back-pressure, mid-flight reset, flush.
module tb_skid_reg;

  localparam int unsigned N = 64;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_d;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_q;
  logic         out_ready;
`ifdef SKID_FLUSH_EN
  logic         flush;
`endif

  int n_cmp = 0;
  int n_err = 0;

  skid_reg #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef SKID_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_d      (in_d),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_q     (out_q),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] next_in;
    logic [63:0] exp_out;
    int          cyc;

    reset     = 1'b1;
    in_valid  = 1'b1;
    in_d      = 64'hFF;
    out_ready = 1'b0;
`ifdef SKID_FLUSH_EN
    flush     = 1'b0;
`endif

    // Reset held 5 cycles with a word offered.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_q", out_q, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_out_q", out_q, 64'd0);

    // Streaming 1..10 with out_ready high.
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_d     = 64'(i);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_out_valid", 64'(out_valid), 64'd1);
      chk("stream_out_q", out_q, 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_out_q_hold", out_q, 64'd10);

    // Stall: offer 6,7,8 with out_ready low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_d      = 64'd6;
    tick();
    chk("stall_q6", out_q, 64'd6);
    chk("stall_rdy_one", 64'(in_ready), 64'd1);
    in_d = 64'd7;
    tick();
    chk("stall_rdy_two", 64'(in_ready), 64'd0);
    chk("stall_q6_two", out_q, 64'd6);
    in_d = 64'd8;
    tick();
    chk("stall_rdy_hold", 64'(in_ready), 64'd0);
    chk("stall_q6_hold", out_q, 64'd6);
    out_ready = 1'b1;
    tick();
    chk("unstall_q7", out_q, 64'd7);
    chk("unstall_valid7", 64'(out_valid), 64'd1);
    chk("unstall_rdy", 64'(in_ready), 64'd1);
    tick();
    chk("unstall_q8", out_q, 64'd8);
    chk("unstall_valid8", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("unstall_empty", 64'(out_valid), 64'd0);

    // Alternating out_ready, words 1..20 must come out in order.
    next_in = 64'd1;
    exp_out = 64'd1;
    cyc     = 0;
    while (exp_out <= 64'd20 && cyc < 200) begin
      out_ready = cyc[0];
      in_valid  = (next_in <= 64'd20);
      in_d      = next_in;
      if (out_valid && out_ready) begin
        chk("alt_out_q", out_q, exp_out);
        exp_out++;
      end
      if (in_valid && in_ready) next_in++;
      tick();
      cyc++;
    end
    chk("alt_all_out", exp_out, 64'd21);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("alt_empty", 64'(out_valid), 64'd0);

    // Reset while holding 3 and 4 in TWO.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_d      = 64'd3;
    tick();
    in_d = 64'd4;
    tick();
    chk("mid_two_rdy", 64'(in_ready), 64'd0);
    chk("mid_two_q", out_q, 64'd3);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_q", out_q, 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mid_after_valid", 64'(out_valid), 64'd0);
    tick();
    chk("mid_after_valid2", 64'(out_valid), 64'd0);

`ifdef SKID_FLUSH_EN
    // Flush in ONE holding 9 while 10 is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_d      = 64'd9;
    tick();
    chk("fl_q9", out_q, 64'd9);
    flush = 1'b1;
    in_d  = 64'd10;
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_q", out_q, 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_after_valid", 64'(out_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
